// File: rtl/operand_sequencer.sv
// operand_sequencer: collects operand A, then operand B, from one shared byte
// stream. It presents the pair as registered op_a/op_b behind a valid/ready
// handshake and counts how many pairs downstream has consumed.
module operand_sequencer #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 clear,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    output logic                 op_valid,
    input  logic                 out_ready,
    output logic                 expect_b,
    output logic [CNT_WIDTH-1:0] pair_count
);

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OUT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       op_a_q, op_a_d;
    logic [WIDTH-1:0]       op_b_q, op_b_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   op_valid_q, op_valid_d;
    logic                   expect_b_q, expect_b_d;
    logic                   in_xfer;
    logic                   out_xfer;

    // The input is blocked while a finished pair is waiting and during clear.
    // This path depends only on state and clear, never on in_data.
    assign in_ready = (state_q != S_OUT) && !clear;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = op_valid_q && out_ready;

    // Next-state, operand loads and pair counting.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_A: begin
                if (in_xfer) begin
                    op_a_d  = in_data;
                    state_d = S_B;
                end
            end
            S_B: begin
                // An abort drops back to S_A without touching op_a; the stale
                // value is simply overwritten by the next A byte.
                if (clear) begin
                    state_d = S_A;
                end else if (in_xfer) begin
                    op_b_d  = in_data;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                // clear is deliberately ignored here so a finished pair is
                // never lost.
                if (out_xfer) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_A;
                end
            end
            default: state_d = S_A;
        endcase
        // Status flags are decoded from the next state so they come straight
        // out of flops.
        op_valid_d = (state_d == S_OUT);
        expect_b_d = (state_d == S_B);
    end

    // State, operand and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_A;
            op_a_q     <= '0;
            op_b_q     <= '0;
            cnt_q      <= '0;
            op_valid_q <= 1'b0;
            expect_b_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            cnt_q      <= cnt_d;
            op_valid_q <= op_valid_d;
            expect_b_q <= expect_b_d;
        end
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_valid   = op_valid_q;
    assign expect_b   = expect_b_q;
    assign pair_count = cnt_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Testbench for operand_sequencer: scenario tasks driven against a
// pair-level reference model.
module tb_operand_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       clear;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_valid;
    logic       out_ready;
    logic       expect_b;
    logic [7:0] pair_count;

    int passed = 0;
    int total  = 0;

    // Reference model: the bytes gathered for the current pair, the pair on
    // offer (if any), and the number of pairs consumed.
    logic [7:0] gathered[$];
    logic       m_full;
    logic [7:0] m_a, m_b;
    int         m_cnt;
    logic       obs_rdy, exp_rdy;

    operand_sequencer #(.WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .clear(clear), .op_a(op_a), .op_b(op_b),
        .op_valid(op_valid), .out_ready(out_ready), .expect_b(expect_b),
        .pair_count(pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one clock cycle: apply inputs, sample in_ready mid-cycle, let the
    // edge happen, then advance the model. Entered and left 1 ns after an edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic c,
                         input logic r, input logic rs);
        logic take;
        in_valid = v; in_data = d; clear = c; out_ready = r; rst = rs;
        #3;
        obs_rdy = in_ready;
        exp_rdy = !m_full && !c;
        take    = v && exp_rdy;
        @(posedge clk);
        #1;
        if (rs) begin
            gathered.delete();
            m_full = 1'b0; m_a = 8'h00; m_b = 8'h00; m_cnt = 0;
        end else if (m_full) begin
            if (r) begin
                m_full = 1'b0;
                m_cnt  = (m_cnt + 1) % 256;
            end
        end else if (gathered.size() == 1 && c) begin
            gathered.delete();
        end else if (take) begin
            gathered.push_back(d);
            if (gathered.size() == 1) m_a = d;
            if (gathered.size() == 2) begin
                m_b    = d;
                m_full = 1'b1;
                gathered.delete();
            end
        end
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        #3;
        total++;
        if ({op_a, op_b, op_valid, expect_b, pair_count} !== 26'd0) begin
            $display("FAIL reset_outputs: got a=%h b=%h v=%b eb=%b cnt=%h, need all 0",
                     op_a, op_b, op_valid, expect_b, pair_count);
        end else passed++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b need 1", in_ready);
        else passed++;
        #(-0);
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        total++;
        if (expect_b !== 1'b1) $display("FAIL basic_expect_b_after_a: got %b need 1", expect_b);
        else passed++;
        cycle(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
        total++;
        if (op_valid !== 1'b1 || op_a !== 8'h3C || op_b !== 8'h0F || expect_b !== 1'b0)
            $display("FAIL basic_pair: got v=%b a=%h b=%h eb=%b need v=1 a=3c b=0f eb=0",
                     op_valid, op_a, op_b, expect_b);
        else passed++;
        total++;
        if ((op_a ^ op_b) !== 8'h33) $display("FAIL basic_xor: got %h need 33", op_a ^ op_b);
        else passed++;
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        total++;
        if (pair_count !== 8'd1 || op_valid !== 1'b0)
            $display("FAIL basic_consume: got cnt=%h v=%b need cnt=01 v=0", pair_count, op_valid);
        else passed++;
    endtask

    task automatic test_stall;
        int bad;
        cycle(1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
            if (obs_rdy !== 1'b0 || op_valid !== 1'b1 || op_a !== 8'h81 || op_b !== 8'h01) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL stall_hold: %0d bad cycles, need 0 (last rdy=%b v=%b a=%h b=%h)",
                               bad, obs_rdy, op_valid, op_a, op_b);
        else passed++;
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        total++;
        if (pair_count !== 8'(m_cnt) || op_valid !== 1'b0)
            $display("FAIL stall_consume: got cnt=%h v=%b need cnt=%h v=0", pair_count, op_valid, 8'(m_cnt));
        else passed++;
        #3;
        total++;
        if (in_ready !== 1'b1) $display("FAIL stall_ready_after: got %b need 1", in_ready);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_clear;
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs_rdy !== 1'b0 || expect_b !== 1'b0 || op_valid !== 1'b0 || op_a !== 8'hAA)
            $display("FAIL clear_in_b: got rdy=%b eb=%b v=%b a=%h need rdy=0 eb=0 v=0 a=aa",
                     obs_rdy, expect_b, op_valid, op_a);
        else passed++;
        cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
        total++;
        if (op_valid !== 1'b1 || op_a !== 8'h12 || op_b !== 8'h34)
            $display("FAIL clear_next_pair: got v=%b a=%h b=%h need v=1 a=12 b=34", op_valid, op_a, op_b);
        else passed++;
        // Clear during a waiting pair must not drop it.
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        total++;
        if (op_valid !== 1'b1 || op_a !== 8'h12 || op_b !== 8'h34)
            $display("FAIL clear_in_out: got v=%b a=%h b=%h need v=1 a=12 b=34", op_valid, op_a, op_b);
        else passed++;
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        total++;
        if (pair_count !== 8'(m_cnt) || op_valid !== 1'b0)
            $display("FAIL clear_consume: got cnt=%h v=%b need cnt=%h v=0", pair_count, op_valid, 8'(m_cnt));
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] a, b;
        int bad;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        bad = 0;
        for (int p = 0; p < 256; p++) begin
            a = 8'($urandom); b = 8'($urandom);
            cycle(1'b1, a, 1'b0, 1'b0, 1'b0);
            cycle(1'b1, b, 1'b0, 1'b0, 1'b0);
            if (op_valid !== 1'b1 || op_a !== a || op_b !== b) bad++;
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            if (p == 254) begin
                total++;
                if (pair_count !== 8'hFF) $display("FAIL b2b_count_max: got %h need ff", pair_count);
                else passed++;
            end
        end
        total++;
        if (bad != 0) $display("FAIL b2b_order: %0d bad pairs, need 0", bad);
        else passed++;
        total++;
        if (pair_count !== 8'h00) $display("FAIL b2b_wrap: got %h need 00", pair_count);
        else passed++;
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
            if (k == 1) cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
            cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
            #3;
            total++;
            if ({op_a, op_b, op_valid, expect_b, pair_count} !== 26'd0 || in_ready !== 1'b1)
                $display("FAIL reset_mid_%0d: got a=%h b=%h v=%b eb=%b cnt=%h rdy=%b need all 0, rdy=1",
                         k, op_a, op_b, op_valid, expect_b, pair_count, in_ready);
            else passed++;
            @(posedge clk); #1;
            cycle(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
            total++;
            if (expect_b !== 1'b1 || op_a !== 8'hC3)
                $display("FAIL reset_mid_first_is_a_%0d: got eb=%b a=%h need eb=1 a=c3", k, expect_b, op_a);
            else passed++;
            cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_random;
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0),
                  1'($urandom), ($urandom_range(0, 63) == 0));
            if (obs_rdy !== exp_rdy) bad++;
            if (op_valid !== m_full) bad++;
            if (expect_b !== (gathered.size() == 1)) bad++;
            if (op_a !== m_a || op_b !== m_b) bad++;
            if (pair_count !== 8'(m_cnt)) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL random_vs_model: %0d mismatching fields, need 0 (cnt=%h model=%h)",
                               bad, pair_count, 8'(m_cnt));
        else passed++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; clear = 1'b0; out_ready = 1'b0;
        m_full = 1'b0; m_a = 8'h00; m_b = 8'h00; m_cnt = 0;
        @(posedge clk); #1;
        test_reset;
        test_basic;
        test_stall;
        test_clear;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
